// File: rtl/bf_stream_sequencer.sv
// Host-side sequencer for the Bellman-Ford compute block: packs a serial word stream into
// a_bus, steps the block through one run, then streams d_bus back out. Optional: BF_RESTART_EN.
module bf_stream_sequencer #(
    parameter int N          = 8,
    parameter int W          = 32,
    parameter int RUN_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_global,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic [N*W-1:0] a_bus,
    output logic           read_enable_global,
    output logic           rollover_phase_counter,
    output logic           phase_counter,
    output logic [1:0]     step_counter,
    input  logic [N*W-1:0] d_bus,
`ifdef BF_RESTART_EN
    input  logic           restart,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           busy
);
    localparam int WCW = $clog2(N);
    localparam int CCW = $clog2(RUN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_SETTLE, S_DRAIN
    } state_t;

    state_t           r_state, w_nxt;
    logic [N*W-1:0]   r_a, r_obuf;
    logic [WCW-1:0]   r_wcnt, r_ocnt;
    logic [CCW-1:0]   r_cyc;
    logic             r_start, r_phase;
    logic [1:0]       r_step;
    logic             w_in_fire, w_out_fire, w_restart;

    // Handshakes are gated by reset so nothing transfers in a reset cycle.
    assign in_ready   = !rst_global && (r_state == S_IDLE || r_state == S_LOAD);
    assign out_valid  = !rst_global && (r_state == S_DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign a_bus              = r_a;
    assign read_enable_global = (r_state == S_START);
    assign phase_counter      = r_phase;
    assign step_counter       = r_step;
    assign out_data           = r_obuf[W-1:0];
    assign out_last           = (r_state == S_DRAIN) && (r_ocnt == WCW'(N-1));
    assign busy               = (r_state != S_IDLE);

`ifdef BF_RESTART_EN
    logic r_roll;
    assign w_restart              = (r_state == S_RUN) && restart;
    assign rollover_phase_counter = r_roll;
    always_ff @(posedge clk) begin
        if (rst_global) r_roll <= 1'b0;
        else            r_roll <= w_restart;
    end
`else
    assign w_restart              = 1'b0;
    assign rollover_phase_counter = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_global) r_state <= S_IDLE;
        else            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_in_fire) w_nxt = S_LOAD;
            S_LOAD:   if (w_in_fire && r_wcnt == WCW'(N-1)) w_nxt = S_START;
            S_START:  if (r_start) w_nxt = S_RUN;
            S_RUN:    if (!w_restart && r_cyc == CCW'(RUN_CYCLES-1)) w_nxt = S_SETTLE;
            S_SETTLE: w_nxt = S_DRAIN;
            S_DRAIN:  if (w_out_fire && r_ocnt == WCW'(N-1)) w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_global) begin
            r_a     <= '0;
            r_obuf  <= '0;
            r_wcnt  <= '0;
            r_ocnt  <= '0;
            r_cyc   <= '0;
            r_start <= 1'b0;
            r_phase <= 1'b0;
            r_step  <= '0;
        end else begin
            if (r_state == S_IDLE && w_in_fire) begin
                r_a[W-1:0] <= in_data;
                r_wcnt     <= WCW'(1);
            end else if (r_state == S_LOAD && w_in_fire) begin
                r_a[int'(r_wcnt)*W +: W] <= in_data;
                r_wcnt                   <= r_wcnt + WCW'(1);
            end

            r_start <= (r_state == S_START) ? !r_start : 1'b0;

            // Run counters are zero outside RUN, so SETTLE and the first RUN cycle see 0.
            if (r_state == S_RUN && w_nxt == S_RUN && !w_restart) begin
                r_cyc   <= r_cyc + CCW'(1);
                r_phase <= !r_phase;
                if (r_phase) r_step <= r_step + 2'd1;
            end else begin
                r_cyc   <= '0;
                r_phase <= 1'b0;
                r_step  <= '0;
            end

            if (r_state == S_SETTLE) begin
                r_obuf <= d_bus;
            end else if (w_out_fire) begin
                r_obuf <= {{W{1'b0}}, r_obuf[N*W-1:W]};
            end

            if (r_state != S_DRAIN)  r_ocnt <= '0;
            else if (w_out_fire)     r_ocnt <= r_ocnt + WCW'(1);
        end
    end
endmodule
